// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the 16-bit ALU and its issue controller.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOT = 4'b0110;
  localparam logic [3:0] ALU_SHL = 4'b0111;
  localparam logic [3:0] ALU_SHR = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_ROL = 4'b1010;
  localparam logic [3:0] ALU_ROR = 4'b1011;
  localparam logic [3:0] ALU_CMP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    DONE
  } state_t;

  function automatic logic is_nop(input logic [3:0] op);
    return op == ALU_NOP;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command handshake and retirement response between the instruction front end and the issue controller.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [AW-1:0]    cmd_rs1;
  logic [AW-1:0]    cmd_rs2;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;
  logic [AW-1:0]    cmd_rd;
  logic             done;
  logic [WIDTH-1:0] done_data;
  logic [2:0]       flags;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_rd,
    input  cmd_ready, done, done_data, flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_rd,
    output cmd_ready, done, done_data, flags
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two combinational read ports, writeback and host write
// with writeback winning when both target the same entry in one cycle.
module alu_regfile #(
  parameter int  WIDTH = 16,
  parameter int  NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    i_rs1_addr,
  output logic [WIDTH-1:0] o_rs1_data,
  input  logic [AW-1:0]    i_rs2_addr,
  output logic [WIDTH-1:0] o_rs2_data,
  input  logic             i_wb_we,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_host_we,
  input  logic [AW-1:0]    i_host_addr,
  input  logic [WIDTH-1:0] i_host_wdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Reads see the pre-edge contents, so a same-cycle write is never forwarded.
  assign o_rs1_data = r_mem[i_rs1_addr];
  assign o_rs2_data = r_mem[i_rs2_addr];

  // NOTE: the array is reset on purpose -- every register must read 0 after reset,
  // which costs a reset-capable flop per bit instead of a RAM macro.
  // NOTE: sequential state uses <= so every entry updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_wb_we && i_wb_addr == AW'(i)) begin
          r_mem[i] <= i_wb_data;
        end else if (i_host_we && i_host_addr == AW'(i)) begin
          r_mem[i] <= i_host_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational 16-bit ALU: accepts register-addressed commands,
// drives the ALU for ALU_LAT cycles, writes the result back and retires with a done pulse.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  NREGS   = 8,
  parameter int  ALU_LAT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  cmd,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_rd,
  input  logic             alu_carry,
  input  logic             alu_eq,
  input  logic             alu_neg,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata
);

  // ALU_LAT is limited to 1..4, so the down-counter never needs more than 2 bits.
  localparam int CW = 2;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_sample;
  logic [2:0]       r_sample_flags;
  logic             r_done;
  logic [WIDTH-1:0] r_done_data;
  logic [2:0]       r_flags;
  logic             w_accept;
  logic             w_wb_we;
  logic [WIDTH-1:0] w_rs1_data;
  logic [WIDTH-1:0] w_rs2_data;

  assign cmd.cmd_ready = (r_state == IDLE);
  assign cmd.done      = r_done;
  assign cmd.done_data = r_done_data;
  assign cmd.flags     = r_flags;
  assign w_accept      = cmd.cmd_valid && (r_state == IDLE);
  assign w_wb_we       = (r_state == WB);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_rs1_addr   (cmd.cmd_rs1),
    .o_rs1_data   (w_rs1_data),
    .i_rs2_addr   (cmd.cmd_rs2),
    .o_rs2_data   (w_rs2_data),
    .i_wb_we      (w_wb_we),
    .i_wb_addr    (r_rd),
    .i_wb_data    (r_sample),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = is_nop(cmd.cmd_op) ? DONE : EXEC;
      EXEC:    if (r_cnt == '0) w_next = WB;
      WB:      w_next = IDLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_rd           <= '0;
      r_sample       <= '0;
      r_sample_flags <= '0;
      r_done         <= 1'b0;
      r_done_data    <= '0;
      r_flags        <= '0;
      alu_op         <= '0;
      alu_in1        <= '0;
      alu_in2        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (is_nop(cmd.cmd_op)) begin
              r_done <= 1'b1;
            end else begin
              alu_op  <= cmd.cmd_op;
              alu_in1 <= w_rs1_data;
              alu_in2 <= cmd.cmd_imm_en ? cmd.cmd_imm : w_rs2_data;
              r_rd    <= cmd.cmd_rd;
              r_cnt   <= CW'(ALU_LAT - 1);
            end
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_sample       <= alu_rd;
            r_sample_flags <= {alu_carry, alu_eq, alu_neg};
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        WB: begin
          r_done      <= 1'b1;
          r_done_data <= r_sample;
          r_flags     <= r_sample_flags;
          alu_op      <= '0;
          alu_in1     <= '0;
          alu_in2     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed commands push expected retirements,
// a monitor per DUT pops and compares on every done pulse.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int AW = 3;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   flags;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q1[$];
  exp_t q3[$];

  alu_issue_ctrl_if #(.WIDTH(W), .AW(AW)) c1 ();
  alu_issue_ctrl_if #(.WIDTH(W), .AW(AW)) c3 ();

  logic [3:0]    a1_op, a3_op;
  logic [W-1:0]  a1_in1, a1_in2, a1_rd, a3_in1, a3_in2, a3_rd;
  logic          a1_c, a1_e, a1_n, a3_c, a3_e, a3_n;
  logic          h1_we, h3_we;
  logic [AW-1:0] h1_addr, h3_addr;
  logic [W-1:0]  h1_wdata, h3_wdata;

  // Behavioural ALU: returns {carry, eq, neg, result}.
  function automatic logic [W+2:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W:0] r;
    case (op)
      ALU_ADD: r = {1'b0, a} + {1'b0, b};
      ALU_SUB: r = {1'b0, a} - {1'b0, b};
      ALU_CMP: r = {1'b0, a} - {1'b0, b};
      ALU_AND: r = {1'b0, a & b};
      ALU_OR:  r = {1'b0, a | b};
      ALU_XOR: r = {1'b0, a ^ b};
      ALU_NOT: r = {1'b0, ~a};
      ALU_SHL: r = {1'b0, a} << b[3:0];
      ALU_SHR: r = {1'b0, a >> b[3:0]};
      ALU_SRA: r = {1'b0, W'($signed(a) >>> b[3:0])};
      ALU_ROL: r = {1'b0, (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}))};
      ALU_ROR: r = {1'b0, (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}))};
      default: r = {1'b0, a};
    endcase
    return {r[W], a == b, r[W-1], r[W-1:0]};
  endfunction

  always_comb {a1_c, a1_e, a1_n, a1_rd} = alu_f(a1_op, a1_in1, a1_in2);
  always_comb {a3_c, a3_e, a3_n, a3_rd} = alu_f(a3_op, a3_in1, a3_in2);

  alu_issue_ctrl #(.WIDTH(W), .NREGS(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .cmd(c1),
    .alu_op(a1_op), .alu_in1(a1_in1), .alu_in2(a1_in2), .alu_rd(a1_rd),
    .alu_carry(a1_c), .alu_eq(a1_e), .alu_neg(a1_n),
    .host_we(h1_we), .host_addr(h1_addr), .host_wdata(h1_wdata)
  );

  alu_issue_ctrl #(.WIDTH(W), .NREGS(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd(c3),
    .alu_op(a3_op), .alu_in1(a3_in1), .alu_in2(a3_in2), .alu_rd(a3_rd),
    .alu_carry(a3_c), .alu_eq(a3_e), .alu_neg(a3_n),
    .host_we(h3_we), .host_addr(h3_addr), .host_wdata(h3_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (c1.done) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected done", 32'(c1.done), 32'd0);
      end else begin
        e = q1.pop_front();
        check({e.name, " data"}, 32'(c1.done_data), 32'(e.data));
        check({e.name, " flags"}, 32'(c1.flags), 32'(e.flags));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (c3.done) begin
      if (q3.size() == 0) begin
        check("dut3 unexpected done", 32'(c3.done), 32'd0);
      end else begin
        e = q3.pop_front();
        check({e.name, " data"}, 32'(c3.done_data), 32'(e.data));
        check({e.name, " flags"}, 32'(c3.flags), 32'(e.flags));
      end
    end
  end

  task automatic push1(input string nm, input logic [W-1:0] d, input logic [2:0] f);
    exp_t e;
    e.data = d; e.flags = f; e.name = nm;
    q1.push_back(e);
  endtask

  task automatic set_cmd(input logic [3:0] op, input int rs1, input int rs2,
                         input logic imm_en, input logic [W-1:0] imm, input int rd);
    c1.cmd_op     = op;
    c1.cmd_rs1    = AW'(rs1);
    c1.cmd_rs2    = AW'(rs2);
    c1.cmd_imm_en = imm_en;
    c1.cmd_imm    = imm;
    c1.cmd_rd     = AW'(rd);
  endtask

  task automatic host_write(input int addr, input logic [W-1:0] data);
    @(negedge clk);
    h1_we = 1'b1; h1_addr = AW'(addr); h1_wdata = data;
    @(posedge clk); #1;
    h1_we = 1'b0;
  endtask

  // hw_off: -1 no host write, 0 host write in the accept cycle, 2 host write in the WB cycle.
  task automatic send(input string nm, input logic [3:0] op, input int rs1, input int rs2,
                      input logic imm_en, input logic [W-1:0] imm, input int rd,
                      input logic [W-1:0] exp_d, input logic [2:0] exp_f, input int exp_lat,
                      input int hw_off, input int hw_addr, input logic [W-1:0] hw_data);
    int  n;
    bit  got;
    push1(nm, exp_d, exp_f);
    @(negedge clk);
    set_cmd(op, rs1, rs2, imm_en, imm, rd);
    c1.cmd_valid = 1'b1;
    n = 0;
    while (!c1.cmd_ready && n < 20) begin @(negedge clk); n++; end
    check({nm, " ready"}, 32'(c1.cmd_ready), 32'd1);
    h1_addr = AW'(hw_addr); h1_wdata = hw_data;
    h1_we   = (hw_off == 0);
    @(posedge clk); #1;
    c1.cmd_valid = 1'b0;
    h1_we        = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      h1_we = (hw_off == 2 && n == 2);
      got   = c1.done;
    end
    h1_we = 1'b0;
    check({nm, " latency"}, 32'(n), 32'(exp_lat));
    check({nm, " alu_op idle"}, 32'(a1_op), 32'd0);
  endtask

  task automatic rb(input string nm, input int r, input logic [W-1:0] v);
    send(nm, ALU_OR, r, 0, 1'b1, '0, r, v, {1'b0, v == '0, v[W-1]}, 3, -1, 0, '0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    exp_t e3;
    c1.cmd_valid = 1'b0; set_cmd(ALU_NOP, 0, 0, 1'b0, '0, 0);
    c3.cmd_valid = 1'b0; c3.cmd_op = ALU_NOP; c3.cmd_rs1 = '0; c3.cmd_rs2 = '0;
    c3.cmd_imm_en = 1'b0; c3.cmd_imm = '0; c3.cmd_rd = '0;
    h1_we = 1'b0; h1_addr = '0; h1_wdata = '0;
    h3_we = 1'b0; h3_addr = '0; h3_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready",     32'(c1.cmd_ready), 32'd1);
    check("reset done",      32'(c1.done),      32'd0);
    check("reset done_data", 32'(c1.done_data), 32'd0);
    check("reset flags",     32'(c1.flags),     32'd0);
    check("reset alu_op",    32'(a1_op),        32'd0);
    check("reset alu_in1",   32'(a1_in1),       32'd0);
    check("reset dut3 ready", 32'(c3.cmd_ready), 32'd1);

    host_write(1, 16'd24);
    host_write(2, 16'd26);
    host_write(5, 16'd3);

    // Register add, immediate subtract with and without a negative result.
    send("add r1+r2", ALU_ADD, 1, 2, 1'b0, '0, 3, 16'd50, 3'b000, 3, -1, 0, '0);
    rb("rb r3", 3, 16'd50);
    send("sub r1-3", ALU_SUB, 1, 0, 1'b1, 16'd3, 4, 16'd21, 3'b000, 3, -1, 0, '0);
    rb("rb r4", 4, 16'd21);
    send("sub r5-24", ALU_SUB, 5, 0, 1'b1, 16'd24, 4, 16'hFFEB, 3'b101, 3, -1, 0, '0);

    // NOP with valid held three cycles: two acceptances, nothing changes.
    push1("nop hold 0", 16'hFFEB, 3'b101);
    push1("nop hold 1", 16'hFFEB, 3'b101);
    @(negedge clk);
    set_cmd(ALU_NOP, 1, 2, 1'b0, 16'h0055, 6);
    c1.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    c1.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("nop hold retired", 32'(q1.size()), 32'd0);
    rb("rb r6 after nop", 6, 16'd0);
    send("nop single", ALU_NOP, 1, 2, 1'b0, 16'h00AA, 6, 16'd0, 3'b010, 1, -1, 0, '0);

    // Back-to-back with valid held high.
    push1("b2b add", 16'd50,   3'b000);
    push1("b2b xor", 16'h00E7, 3'b000);
    push1("b2b sub", 16'd0,    3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0:       set_cmd(ALU_ADD, 1, 2, 1'b0, '0, 3);
        1:       set_cmd(ALU_XOR, 1, 0, 1'b1, 16'h00FF, 6);
        default: set_cmd(ALU_SUB, 1, 1, 1'b0, '0, 7);
      endcase
      c1.cmd_valid = 1'b1;
      w = 0;
      while (!c1.cmd_ready && w < 20) begin @(negedge clk); w++; end
      if (i > 0) check("b2b ready-low cycles", 32'(w), 32'd2);
      @(posedge clk); #1;
    end
    c1.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b retired", 32'(q1.size()), 32'd0);
    rb("rb r6 after b2b", 6, 16'h00E7);

    // Host write collisions: accept-cycle write to rs1, WB-cycle write to rd.
    send("add old r1", ALU_ADD, 1, 2, 1'b0, '0, 0, 16'd50, 3'b000, 3, 0, 1, 16'd100);
    rb("rb r1 host", 1, 16'd100);
    send("add wb wins", ALU_ADD, 1, 2, 1'b0, '0, 7, 16'h007E, 3'b000, 3, 2, 7, 16'h1234);
    rb("rb r7 wb", 7, 16'h007E);
    send("pre-reset sub", ALU_SUB, 5, 0, 1'b1, 16'd24, 4, 16'hFFEB, 3'b101, 3, -1, 0, '0);

    // Reset while in EXEC: command aborted, everything cleared.
    @(negedge clk);
    set_cmd(ALU_ADD, 1, 2, 1'b0, '0, 3);
    c1.cmd_valid = 1'b1;
    @(posedge clk); #1;
    c1.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort ready",     32'(c1.cmd_ready), 32'd1);
    check("abort flags",     32'(c1.flags),     32'd0);
    check("abort done_data", 32'(c1.done_data), 32'd0);
    check("abort alu_op",    32'(a1_op),        32'd0);
    repeat (5) @(negedge clk);
    rb("rb r1 abort", 1, 16'd0);
    rb("rb r3 abort", 3, 16'd0);
    rb("rb r4 abort", 4, 16'd0);

    // ALU_LAT = 3 instance: scenario 1 retires five cycles after accept.
    @(negedge clk);
    h3_we = 1'b1; h3_addr = 3'd1; h3_wdata = 16'd24;
    @(negedge clk);
    h3_addr = 3'd2; h3_wdata = 16'd26;
    @(negedge clk);
    h3_we = 1'b0;
    e3.data = 16'd50; e3.flags = 3'b000; e3.name = "lat3 add";
    q3.push_back(e3);
    c3.cmd_op = ALU_ADD; c3.cmd_rs1 = 3'd1; c3.cmd_rs2 = 3'd2; c3.cmd_rd = 3'd3;
    c3.cmd_imm_en = 1'b0; c3.cmd_valid = 1'b1;
    check("lat3 ready", 32'(c3.cmd_ready), 32'd1);
    @(posedge clk); #1;
    c3.cmd_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!c3.done && w < 20);
    check("lat3 latency", 32'(w), 32'd5);

    repeat (3) @(negedge clk);
    check("dut1 pending", 32'(q1.size()), 32'd0);
    check("dut3 pending", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
